// File: rtl/htif_pcr_responder.sv
// Host PCR request/reply responder owning the tohost (0x780) and fromhost (0x781) registers.
// Define PCR_CYCLE_COUNTER_EN to map a free-running cycle counter at 12'hC00.
//
// state | meaning
// IDLE  | ready for a host request
// RESP  | reply held on rep_bits until the host accepts it
module htif_pcr_responder #(
   parameter int unsigned XLEN = 64,
   parameter int unsigned ADDR_W = 12,
   parameter logic [ADDR_W-1:0] TOHOST_ADDR = 12'h780,
   parameter logic [ADDR_W-1:0] FROMHOST_ADDR = 12'h781
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              io_host_pcr_req_valid,
   output logic              io_host_pcr_req_ready,
   input  logic              io_host_pcr_req_bits_rw,
   input  logic [ADDR_W-1:0] io_host_pcr_req_bits_addr,
   input  logic [XLEN-1:0]   io_host_pcr_req_bits_data,
   output logic              io_host_pcr_rep_valid,
   input  logic              io_host_pcr_rep_ready,
   output logic [XLEN-1:0]   io_host_pcr_rep_bits,
   input  logic              core_tohost_valid,
   output logic              core_tohost_ready,
   input  logic [XLEN-1:0]   core_tohost_data,
   output logic              core_fromhost_valid,
   output logic [XLEN-1:0]   core_fromhost_data,
   input  logic              core_fromhost_clear
);

   typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [XLEN-1:0]   r_rep_bits;
   logic [XLEN-1:0]   r_tohost;
   logic [XLEN-1:0]   r_fromhost;
   logic [XLEN-1:0]   w_rd_data;
   logic              w_fire;
   logic              w_hit_tohost;
   logic              w_hit_fromhost;
   logic              w_core_wr;

`ifdef PCR_CYCLE_COUNTER_EN
   localparam logic [ADDR_W-1:0] CYCLE_ADDR = ADDR_W'(12'hC00);
   logic [XLEN-1:0]   r_cycle;

   always_ff @(posedge clk) begin
      if (reset) r_cycle <= '0;
      else       r_cycle <= r_cycle + 1'b1;
   end
`endif

   assign io_host_pcr_req_ready = (r_state == IDLE) && !reset;
   assign io_host_pcr_rep_valid = (r_state == RESP);
   assign io_host_pcr_rep_bits  = r_rep_bits;

   assign w_fire         = io_host_pcr_req_valid && io_host_pcr_req_ready;
   assign w_hit_tohost   = w_fire && (io_host_pcr_req_bits_addr == TOHOST_ADDR);
   assign w_hit_fromhost = w_fire && (io_host_pcr_req_bits_addr == FROMHOST_ADDR);

   // The host owns tohost in any cycle it touches it; the core retries next cycle.
   assign core_tohost_ready   = !reset && (r_tohost == '0) && !w_hit_tohost;
   assign w_core_wr           = core_tohost_valid && core_tohost_ready;
   assign core_fromhost_valid = (r_fromhost != '0);
   assign core_fromhost_data  = r_fromhost;

   always_comb begin
      w_rd_data = '0;
      if (io_host_pcr_req_bits_addr == TOHOST_ADDR)
         w_rd_data = r_tohost;
      else if (io_host_pcr_req_bits_addr == FROMHOST_ADDR)
         w_rd_data = r_fromhost;
`ifdef PCR_CYCLE_COUNTER_EN
      else if (io_host_pcr_req_bits_addr == CYCLE_ADDR)
         w_rd_data = r_cycle;
`endif
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: if (w_fire) w_state_nxt = RESP;
         RESP: if (io_host_pcr_rep_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_rep_bits <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_fire) r_rep_bits <= w_rd_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_tohost <= '0;
      end else if (w_hit_tohost) begin
         r_tohost <= io_host_pcr_req_bits_rw ? io_host_pcr_req_bits_data : '0;
      end else if (w_core_wr) begin
         r_tohost <= core_tohost_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_fromhost <= '0;
      end else if (w_hit_fromhost && io_host_pcr_req_bits_rw) begin
         r_fromhost <= io_host_pcr_req_bits_data;
      end else if (core_fromhost_clear) begin
         r_fromhost <= '0;
      end
   end

endmodule

// File: doc/htif_pcr_responder.md
Name: htif_pcr_responder

Overview:
- Target-side responder for the host PCR (CSR) request/reply channel that the test harness drives as initiator.
- Owns the tohost (0x780) and fromhost (0x781) registers.
- Serves host read/write requests and returns one reply per accepted request.
- Gives the core a write port into tohost and a read/clear port for fromhost.
- Sits between the host interface pins and the core's CSR file in the top-level wrapper.

Parameters:
- XLEN, 64, data width of the request data, reply data and tohost/fromhost registers.
- ADDR_W, 12, PCR address width.
- TOHOST_ADDR, 12'h780, address of tohost.
- FROMHOST_ADDR, 12'h781, address of fromhost.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- io_host_pcr_req_valid  in  1  host request valid
- io_host_pcr_req_ready  out  1  responder can accept a request
- io_host_pcr_req_bits_rw  in  1  1=write, 0=read
- io_host_pcr_req_bits_addr  in  ADDR_W  PCR address
- io_host_pcr_req_bits_data  in  XLEN  write data
- io_host_pcr_rep_valid  out  1  reply valid
- io_host_pcr_rep_ready  in  1  host accepts reply
- io_host_pcr_rep_bits  out  XLEN  reply data
- core_tohost_valid  in  1  core writes tohost
- core_tohost_ready  out  1  core write accepted this cycle
- core_tohost_data  in  XLEN  core tohost value
- core_fromhost_valid  out  1  fromhost nonzero
- core_fromhost_data  out  XLEN  fromhost contents
- core_fromhost_clear  in  1  core clears fromhost

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: state=IDLE, req_ready=0 during reset, rep_valid=0, rep_bits=0, tohost=0, fromhost=0, core_tohost_ready=0, core_fromhost_valid=0.
- Reset mid-operation: an asserted reset discards any pending reply; no reply is ever produced for that request.
- FSM states: IDLE and RESP.
  - IDLE: req_ready=1. A request fires when req_valid && req_ready. On fire, the reply data is latched and the FSM moves to RESP.
  - RESP: req_ready=0, rep_valid=1. rep_bits stays stable until rep_valid && rep_ready, then the FSM returns to IDLE.
- Latency and throughput: the reply is valid the cycle after the request fires. Maximum throughput is one request per 2 cycles. Back-to-back fire is permitted in the cycle the FSM re-enters IDLE.
- Address decode: each fired request returns the pre-update register value, then applies its effect at the same edge.
  - Read of TOHOST_ADDR: reply = tohost, then tohost cleared to 0 (read-clear).
  - Write of TOHOST_ADDR: tohost <= data.
  - Read of FROMHOST_ADDR: reply = fromhost, no side effect.
  - Write of FROMHOST_ADDR: fromhost <= data.
  - Unmapped address: reply 0, no state change.
- Core tohost port: core_tohost_ready = (tohost==0) && !(request fires to TOHOST_ADDR this cycle). When valid && ready, tohost <= core_tohost_data.
  - Writing 0 is accepted and leaves tohost at 0.
- Core fromhost port: core_fromhost_valid = (fromhost!=0); core_fromhost_data = fromhost.
  - core_fromhost_clear sets fromhost to 0.
  - If a host write to FROMHOST_ADDR fires in the same cycle as clear, the host write wins.
- Widths: all registers are XLEN bits. Address compare uses the full ADDR_W bits. There is no sign extension.

Optional Feature:
- Macro: PCR_CYCLE_COUNTER_EN.
- When defined:
  - An XLEN-bit free-running cycle counter is added, reset to 0 and incremented every non-reset cycle, wrapping at 2^XLEN.
  - A read of 12'hC00 returns the counter value at the fire edge.
  - A write to 12'hC00 is ignored and replies with the current value.
- When undefined: 12'hC00 is unmapped (reply 0). No counter flops exist.

Test Plan:
1. Core writes tohost=5 (ready=1), then host reads 0x780 -> reply 5 one cycle after fire; tohost=0 afterwards; core_tohost_ready returns to 1.
2. Host polls 0x780 with rep_ready=1 while tohost=0 -> reply 0 on every poll; a core write of 3 lands and the next poll returns 3.
3. Host writes 0x781=0xABCD -> reply 0 (old value), core_fromhost_valid=1, data=0xABCD. Core clear -> valid=0. Simultaneous clear and host write of 7 -> fromhost=7.
4. Reply backpressure: rep_ready=0 for 4 cycles -> rep_valid and rep_bits stay stable, req_ready=0 throughout. Reply accepted when rep_ready rises; next request accepted the following cycle.
5. Collision: tohost=0, host read of 0x780 and core write of 9 in the same cycle -> core_tohost_ready=0 that cycle, reply 0. Core write lands next cycle; a subsequent read returns 9.
6. Reset asserted while in RESP -> rep_valid=0 the next cycle, tohost and fromhost=0. Read of unmapped 0x123 after reset -> reply 0. With PCR_CYCLE_COUNTER_EN, read of 0xC00 10 cycles after reset release -> reply 10.
